// File: rtl/param_shift_unit.sv
// Multi-cycle barrel shifter: moves the operand up to STEP positions per clock
// in logical, arithmetic or rotate mode, then pulses done for one cycle.
module param_shift_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1,
    localparam int unsigned SW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] in,
    input  logic [SW-1:0]    shift,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [SW-1:0] StepAmt = SW'(STEP);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   val_q, val_d;
    logic [SW-1:0]      rem_q, rem_d;
    logic               dir_q, dir_d;
    logic [1:0]         mode_q, mode_d;

    logic [SW-1:0]      step_k;
    logic [SW-1:0]      rem_next;
    logic [WIDTH-1:0]   fill;
    logic [WIDTH-1:0]   shifted;
    logic [2*WIDTH-1:0] wide;

    // The fill word supplies the vacated bits: a copy of the value for rotate,
    // the sign for arithmetic right, zeros otherwise (incl. mode 11).
    always_comb begin
        step_k   = (rem_q > StepAmt) ? StepAmt : rem_q;
        rem_next = rem_q - step_k;
        if (mode_q == 2'b10) begin
            fill = val_q;
        end else if (mode_q == 2'b01 && dir_q) begin
            fill = {WIDTH{val_q[WIDTH-1]}};
        end else begin
            fill = '0;
        end
        if (dir_q) begin
            wide    = {fill, val_q} >> step_k;
            shifted = wide[WIDTH-1:0];
        end else begin
            wide    = {val_q, fill} << step_k;
            shifted = wide[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    val_d   = in;
                    rem_d   = shift;
                    dir_d   = dir;
                    mode_d  = mode;
                    state_d = (shift != '0) ? StShift : StDone;
                end
            end
            StShift: begin
                if (en) begin
                    val_d = shifted;
                    rem_d = rem_next;
                    if (rem_next == '0) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= StIdle;
            val_q   <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
        end
    end

    assign q    = val_q;
    assign busy = (state_q == StShift);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_param_shift_unit.sv
// Directed bench for param_shift_unit: a STEP=1 and a STEP=4 instance (WIDTH=32)
// driven from a vector table plus hand sequences for start/en/clr corner cases.
module tb_param_shift_unit;

    logic        clk = 1'b0;
    logic        clr;
    logic        start1, start4;
    logic        en;
    logic        dir;
    logic [1:0]  mode;
    logic [31:0] din;
    logic [5:0]  shift;
    logic [31:0] q1, q4;
    logic        busy1, busy4, done1, done4;

    logic        sel;
    logic [31:0] qs;
    logic        busys, dones;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    param_shift_unit #(.WIDTH(32), .STEP(1)) u_dut1 (
        .clk(clk), .clr(clr), .start(start1), .en(en), .dir(dir), .mode(mode),
        .in(din), .shift(shift), .q(q1), .busy(busy1), .done(done1)
    );

    param_shift_unit #(.WIDTH(32), .STEP(4)) u_dut4 (
        .clk(clk), .clr(clr), .start(start4), .en(en), .dir(dir), .mode(mode),
        .in(din), .shift(shift), .q(q4), .busy(busy4), .done(done4)
    );

    assign qs    = sel ? q4 : q1;
    assign busys = sel ? busy4 : busy1;
    assign dones = sel ? done4 : done1;

    typedef struct {
        logic        sel;
        logic [1:0]  mode;
        logic        dir;
        logic [5:0]  sh;
        logic [31:0] din;
        logic [31:0] exp_q;
        int          exp_busy;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic s, input logic [1:0] m, input logic d,
                          input logic [31:0] di, input logic [5:0] sh,
                          output int nbusy, output bit got_done);
        @(negedge clk);
        sel    = s;
        start1 = !s;
        start4 = s;
        mode   = m;
        dir    = d;
        din    = di;
        shift  = sh;
        @(negedge clk);
        start1 = 1'b0;
        start4 = 1'b0;
        nbusy    = 0;
        got_done = 0;
        for (int i = 0; i < 200 && !got_done; i++) begin
            if (dones) begin
                got_done = 1;
            end else begin
                if (busys) nbusy++;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int nb;
        bit gd;
        bit bad;
        logic [31:0] qfreeze;
        logic [31:0] exp_freeze;
        logic [31:0] base;

        vecs[0]  = '{1'b0, 2'b00, 1'b0, 6'd27, 32'h7105c1a6, 32'h30000000, 27};
        vecs[1]  = '{1'b1, 2'b00, 1'b0, 6'd27, 32'h7105c1a6, 32'h30000000, 7};
        vecs[2]  = '{1'b1, 2'b10, 1'b1, 6'd4,  32'h7105c1a6, 32'h67105c1a, 1};
        vecs[3]  = '{1'b0, 2'b01, 1'b1, 6'd31, 32'h80000000, 32'hffffffff, 31};
        vecs[4]  = '{1'b0, 2'b00, 1'b1, 6'd31, 32'h80000000, 32'h00000001, 31};
        vecs[5]  = '{1'b1, 2'b01, 1'b1, 6'd31, 32'h80000000, 32'hffffffff, 8};
        vecs[6]  = '{1'b0, 2'b00, 1'b0, 6'd0,  32'h12345678, 32'h12345678, 0};
        vecs[7]  = '{1'b1, 2'b10, 1'b0, 6'd36, 32'h7105c1a6, 32'h105c1a67, 9};
        vecs[8]  = '{1'b1, 2'b00, 1'b0, 6'd40, 32'h7105c1a6, 32'h00000000, 10};
        vecs[9]  = '{1'b1, 2'b01, 1'b1, 6'd63, 32'h80000000, 32'hffffffff, 16};
        vecs[10] = '{1'b1, 2'b01, 1'b0, 6'd8,  32'h80ff00ff, 32'hff00ff00, 2};
        vecs[11] = '{1'b0, 2'b01, 1'b1, 6'd5,  32'h40000000, 32'h02000000, 5};
        vecs[12] = '{1'b1, 2'b11, 1'b1, 6'd5,  32'hf0000000, 32'h07800000, 2};
        vecs[13] = '{1'b0, 2'b10, 1'b1, 6'd33, 32'h00000001, 32'h80000000, 33};
        vecs[14] = '{1'b1, 2'b10, 1'b0, 6'd32, 32'hdeadbeef, 32'hdeadbeef, 8};

        clr    = 1'b1;
        start1 = 1'b0;
        start4 = 1'b0;
        en     = 1'b1;
        dir    = 1'b0;
        mode   = 2'b00;
        din    = '0;
        shift  = '0;
        sel    = 1'b0;

        repeat (2) @(negedge clk);
        check("reset q", {q4, q1}, 64'h0);
        check("reset busy/done", {60'h0, busy1, busy4, done1, done4}, 64'h0);
        clr = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].sel, vecs[i].mode, vecs[i].dir, vecs[i].din, vecs[i].sh, nb, gd);
            check($sformatf("vec%0d done seen", i), 64'(gd), 64'h1);
            check($sformatf("vec%0d q", i), 64'(qs), 64'(vecs[i].exp_q));
            check($sformatf("vec%0d busy cycles", i), 64'(nb), 64'(vecs[i].exp_busy));
            @(negedge clk);
            check($sformatf("vec%0d done one cycle", i), {62'h0, busys, dones}, 64'h0);
            check($sformatf("vec%0d q held", i), 64'(qs), 64'(vecs[i].exp_q));
        end

        // start held high: inputs changed after acceptance must not leak in
        @(negedge clk);
        sel = 1'b0; start1 = 1'b1; din = 32'h1; shift = 6'd3; mode = 2'b00; dir = 1'b0;
        @(negedge clk);
        din = 32'hffffffff; shift = 6'd1; dir = 1'b1;
        nb = 0; gd = 0;
        for (int i = 0; i < 20 && !gd; i++) begin
            if (done1) gd = 1;
            else begin
                if (busy1) nb++;
                @(negedge clk);
            end
        end
        check("held start first busy", 64'(nb), 64'd3);
        check("held start first q", 64'(q1), 64'h8);
        @(negedge clk);
        check("held start idle gap", {62'h0, busy1, done1}, 64'h0);
        @(negedge clk);
        check("held start second busy", 64'(busy1), 64'h1);
        start1 = 1'b0;
        @(negedge clk);
        check("held start second done", 64'(done1), 64'h1);
        check("held start second q", 64'(q1), 64'h7fffffff);
        @(negedge clk);

        // en low for 5 cycles mid-operation
        din = 32'h7105c1a6; shift = 6'd27; mode = 2'b00; dir = 1'b0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        base = 32'h7105c1a6;
        exp_freeze = base << 10;
        nb = 0; gd = 0; bad = 0; qfreeze = '0;
        for (int i = 0; i < 100 && !gd; i++) begin
            if (i == 10) begin
                qfreeze = q1;
                en = 1'b0;
            end
            if (i > 10 && i <= 15 && (q1 !== qfreeze || busy1 !== 1'b1)) bad = 1;
            if (i == 15) en = 1'b1;
            if (done1) gd = 1;
            else begin
                if (busy1) nb++;
                @(negedge clk);
            end
        end
        check("freeze q value", 64'(qfreeze), 64'(exp_freeze));
        check("freeze held", 64'(bad), 64'h0);
        check("freeze busy total", 64'(nb), 64'd32);
        check("freeze final q", 64'(q1), 64'h30000000);
        @(negedge clk);

        // asynchronous clear mid-operation
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (10) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        check("clr q", 64'(q1), 64'h0);
        check("clr busy/done", {62'h0, busy1, done1}, 64'h0);
        #1 clr = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (done1 || busy1) bad = 1;
        end
        check("clr no done pulse", 64'(bad), 64'h0);
        run_op(1'b0, 2'b00, 1'b0, 32'h7105c1a6, 6'd27, nb, gd);
        check("after clr done", 64'(gd), 64'h1);
        check("after clr q", 64'(q1), 64'h30000000);
        check("after clr busy", 64'(nb), 64'd27);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
